// File: rtl/adc_capture_pkg.sv
// Shared constants and helpers for the ADC sample capture block.
//   SEQ_W / STUCK_CNT_W : sequence tag and stuck-counter widths
//   DEF_*               : parameter defaults used by adc_sample_capture
//   CAPT_FALL/CAPT_RISE : values of the CAPT_EDGE parameter
package adc_capture_pkg;

  localparam int unsigned SEQ_W       = 8;
  localparam int unsigned STUCK_CNT_W = 8;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_N_CH        = 1;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CAPT_EDGE   = 0;
  localparam int unsigned DEF_SROUT_DELAY = 1;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_STUCK_LIMIT = 200;

  localparam int unsigned CAPT_FALL = 0;
  localparam int unsigned CAPT_RISE = 1;

  // Saturating increment used by the stuck-high monitor.
  function automatic logic [STUCK_CNT_W-1:0] sat_inc(
    input logic [STUCK_CNT_W-1:0] cnt,
    input logic [STUCK_CNT_W-1:0] limit
  );
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO: RD_DATA always presents the head entry.
//   CLK, RST_N : clock, async active-low reset (empties FIFO, zeroes storage)
//   WR_EN      : write request; accepted when not full, or when full and a
//                read happens in the same cycle
//   RD_EN      : pop the head entry; ignored when empty
//   RD_DATA    : head entry
//   FULL/EMPTY : occupancy status
module sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    EMPTY   = (wr_ptr == rd_ptr);
    FULL    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_rd   = RD_EN & ~EMPTY;
    do_wr   = WR_EN & (~FULL | do_rd);
    RD_DATA = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= WR_DATA;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sample_capture.sv
// Captures N_CH parallel ADC words plus SR_OUT flags on a selected edge of
// the asynchronous conversion clock, tags them with a sequence number and
// queues them in a show-ahead FIFO.
//   CLK, RST_N          : system clock, async active-low reset
//   ENABLE              : capture enable (FIFO drains regardless)
//   CLR_STATUS          : clears OVERFLOW, SROUT_STUCK and stuck counters
//   CNVCLK_IN           : ADC conversion clock (asynchronous)
//   DATA_IN, SR_OUT_IN  : ADC words / SR_OUT flags, channel c at [c*DATA_W +: DATA_W]
//   OUT_VALID/OUT_READY : FIFO head handshake
//   OUT_DATA/SROUT/SEQ  : head entry fields
//   SROUT_STUCK         : sticky per-channel stuck-high flag
//   OVERFLOW            : sticky sample-dropped flag
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CAPT_EDGE   = DEF_CAPT_EDGE,
  parameter int unsigned SROUT_DELAY = DEF_SROUT_DELAY,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   ENABLE,
  input  logic                   CLR_STATUS,
  input  logic                   CNVCLK_IN,
  input  logic [N_CH*DATA_W-1:0] DATA_IN,
  input  logic [N_CH-1:0]        SR_OUT_IN,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [N_CH*DATA_W-1:0] OUT_DATA,
  output logic [N_CH-1:0]        OUT_SROUT,
  output logic [SEQ_W-1:0]       OUT_SEQ,
  output logic [N_CH-1:0]        SROUT_STUCK,
  output logic                   OVERFLOW
);

  localparam int unsigned LAST   = SYNC_STAGES - 1;
  localparam int unsigned DLY_N  = (SROUT_DELAY == 0) ? 1 : SROUT_DELAY;
  localparam int unsigned FIFO_W = SEQ_W + N_CH + N_CH * DATA_W;
  localparam logic [STUCK_CNT_W-1:0] LIMIT = STUCK_CNT_W'(STUCK_LIMIT);

  // Synchroniser and aligned data chains
  logic [SYNC_STAGES-1:0]  cnv_sync;
  logic                    cnv_hist;
  logic                    edge_seen;
  logic                    capt_pulse;
  logic                    capt_en;
  logic [N_CH*DATA_W-1:0]  data_sync [SYNC_STAGES];
  logic [N_CH-1:0]         sr_sync   [SYNC_STAGES];

  // SR_OUT delay line and stuck monitor
  logic [N_CH-1:0]         sr_dly [DLY_N];
  logic [N_CH-1:0]         sr_delayed;
  logic [N_CH-1:0]         sr_store;
  logic [N_CH-1:0]         stuck_hit;
  logic [N_CH-1:0]         stuck_q;
  logic [STUCK_CNT_W-1:0]  stuck_cnt [N_CH];
  logic [STUCK_CNT_W-1:0]  cnt_next  [N_CH];

  // Write stage and FIFO
  logic [SEQ_W-1:0]        seq_q;
  logic                    wr_req;
  logic [FIFO_W-1:0]       wr_data;
  logic [FIFO_W-1:0]       rd_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    rd_fire;
  logic                    ovf_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnv_sync   <= '0;
      cnv_hist   <= 1'b0;
      capt_pulse <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        data_sync[i] <= '0;
        sr_sync[i]   <= '0;
      end
    end else begin
      cnv_sync     <= {cnv_sync[SYNC_STAGES-2:0], CNVCLK_IN};
      cnv_hist     <= cnv_sync[LAST];
      capt_pulse   <= edge_seen;
      data_sync[0] <= DATA_IN;
      sr_sync[0]   <= SR_OUT_IN;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        data_sync[i] <= data_sync[i-1];
        sr_sync[i]   <= sr_sync[i-1];
      end
    end
  end

  always_comb begin
    if (CAPT_EDGE == CAPT_RISE) begin
      edge_seen = cnv_sync[LAST] & ~cnv_hist;
    end else begin
      edge_seen = ~cnv_sync[LAST] & cnv_hist;
    end
  end

  assign capt_en = capt_pulse & ENABLE;

  // The stuck counter update and the stored SR_OUT forcing are resolved in
  // the same cycle so the entry that reaches the limit is already masked.
  always_comb begin
    sr_delayed = (SROUT_DELAY == 0) ? sr_sync[LAST] : sr_dly[DLY_N-1];
    for (int unsigned c = 0; c < N_CH; c++) begin
      cnt_next[c]  = CLR_STATUS ? '0 : stuck_cnt[c];
      stuck_hit[c] = 1'b0;
      if (capt_en) begin
        cnt_next[c]  = sr_delayed[c] ? sat_inc(cnt_next[c], LIMIT) : '0;
        stuck_hit[c] = (cnt_next[c] == LIMIT);
      end
      sr_store[c] = sr_delayed[c] & ~stuck_hit[c];
    end
  end

  // capt_pulse is registered, so data_sync[LAST] here is one sample past the
  // edge; still inside the required DATA_IN stable window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seq_q   <= '0;
      wr_req  <= 1'b0;
      wr_data <= '0;
      stuck_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < DLY_N; i++) begin
        sr_dly[i] <= '0;
      end
      for (int unsigned c = 0; c < N_CH; c++) begin
        stuck_cnt[c] <= '0;
      end
    end else begin
      wr_req <= capt_en;
      if (capt_en) begin
        wr_data   <= {seq_q, sr_store, data_sync[LAST]};
        seq_q     <= seq_q + 1'b1;
        sr_dly[0] <= sr_sync[LAST];
        for (int unsigned i = 1; i < DLY_N; i++) begin
          sr_dly[i] <= sr_dly[i-1];
        end
      end
      for (int unsigned c = 0; c < N_CH; c++) begin
        stuck_cnt[c] <= cnt_next[c];
        if (stuck_hit[c]) begin
          stuck_q[c] <= 1'b1;
        end else if (CLR_STATUS) begin
          stuck_q[c] <= 1'b0;
        end
      end
      if (wr_req && fifo_full && !rd_fire) begin
        ovf_q <= 1'b1;
      end else if (CLR_STATUS) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign rd_fire = ~fifo_empty & OUT_READY;

  sample_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WR_EN   (wr_req),
    .WR_DATA (wr_data),
    .RD_EN   (rd_fire),
    .RD_DATA (rd_data),
    .FULL    (fifo_full),
    .EMPTY   (fifo_empty)
  );

  assign OUT_VALID   = ~fifo_empty;
  assign OUT_DATA    = rd_data[N_CH*DATA_W-1:0];
  assign OUT_SROUT   = rd_data[N_CH*DATA_W +: N_CH];
  assign OUT_SEQ     = rd_data[FIFO_W-1 -: SEQ_W];
  assign SROUT_STUCK = stuck_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: doc/adc_sample_capture.md
# adc_sample_capture

Parametrised successor to the single-channel ADC sample receiver: captures N_CH parallel ADC words plus per-channel SR_OUT flags on a selectable edge of the conversion clock. The conversion clock is treated as an asynchronous data input, synchronised and edge-detected in the CLK domain. Captured samples are tagged with a sequence number and buffered in a small FIFO with a valid/ready output. A per-channel SR_OUT stuck-high monitor is included. Sits between the ADC pins and the downstream packetiser.

## Interface
Parameters:
- DATA_W, 16: bits per ADC channel.
- N_CH, 1: number of channels sharing one conversion clock.
- SYNC_STAGES, 2: synchroniser depth for CNVCLK_IN; legal range 2..4.
- CAPT_EDGE, 0: 0 = capture on CNVCLK_IN falling edge, 1 = rising edge.
- SROUT_DELAY, 1: extra conversions of delay applied to SR_OUT relative to data; legal range 0..3.
- FIFO_DEPTH, 8: output FIFO entries; power of 2, ≥ 2.
- STUCK_LIMIT, 200: consecutive high SR_OUT conversions that declare a stuck channel; ≤ 255.

Ports:
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  capture enable.
- CLR_STATUS  in  1  one-cycle pulse; clears OVERFLOW, SROUT_STUCK and the stuck counters.
- CNVCLK_IN  in  1  ADC conversion clock, asynchronous.
- DATA_IN  in  N_CH*DATA_W  ADC words; channel c occupies [c*DATA_W +: DATA_W].
- SR_OUT_IN  in  N_CH  per-channel SR_OUT flags.
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  consumer accepts the head entry.
- OUT_DATA  out  N_CH*DATA_W  head data.
- OUT_SROUT  out  N_CH  head SR_OUT flags.
- OUT_SEQ  out  8  head sequence number.
- SROUT_STUCK  out  N_CH  sticky stuck-high flag.
- OVERFLOW  out  1  sticky flag; a sample was dropped because the FIFO was full.

## Operation
- CNVCLK_IN passes through SYNC_STAGES flops, then one edge-history flop. The capture pulse is asserted when the selected edge is seen.
- DATA_IN and SR_OUT_IN pass through an identical SYNC_STAGES-deep register chain, so each captured word is aligned with its edge. DATA_IN must be stable for ≥ SYNC_STAGES+1 CLK cycles after the edge. CLK must be ≥ 8× the CNVCLK_IN frequency.
- SR_OUT pipeline: the captured SR_OUT is delayed by SROUT_DELAY conversions through a shift register that advances only on capture pulses.
- Stuck monitor, per channel, clocked on capture pulses:
  - Delayed SR_OUT = 1: 8-bit counter increments, saturating at STUCK_LIMIT.
  - Delayed SR_OUT = 0: counter clears.
  - Counter == STUCK_LIMIT: set SROUT_STUCK[c] and force that channel's stored SR_OUT to 0.
  - Stuck-flag set and CLR_STATUS in the same cycle: set wins.
- Sequence counter, 8-bit, wraps 255→0. Increments on every capture pulse, including dropped samples, so gaps are visible downstream.
- ENABLE = 0: capture pulses ignored; stuck counters and sequence counter hold; FIFO keeps draining.
- FIFO write (show-ahead), on every capture pulse with ENABLE = 1:
  - Not full: write {seq, srout, data}.
  - Full: drop the sample and set OVERFLOW.
  - OVERFLOW set and CLR_STATUS in the same cycle: set wins.
- FIFO read: occurs when OUT_VALID & OUT_READY. A write and a read in the same cycle while full: the read frees the slot and the write succeeds, no overflow.
- Reset values: all outputs 0, FIFO empty, all counters 0, synchroniser history 0. A falling edge is therefore not falsely detected after reset.

## Timing
- Latency: CNVCLK_IN edge sampled by the first sync flop at edge k → capture pulse at k+SYNC_STAGES → FIFO write at k+SYNC_STAGES+1 → OUT_VALID high after edge k+SYNC_STAGES+2 (empty FIFO, SYNC_STAGES = 2: 4 cycles).
- OUT_DATA, OUT_SROUT and OUT_SEQ must be stable while OUT_VALID = 1 and OUT_READY = 0.
- Throughput: one sample per CLK cycle at the output; input rate is bounded by CNVCLK_IN.

## Structure
- Package adc_capture_pkg: SEQ_W = 8, STUCK_CNT_W = 8, parameter defaults, and the CAPT_FALL/CAPT_RISE constants.
- One sub-module, sample_fifo: a parametrised width/depth synchronous show-ahead FIFO with full/empty outputs.
- Synchroniser, stuck monitor and sequence counter are implemented inline.

## Test plan
- Single capture: CAPT_EDGE = 0, DATA_IN = 16'hA5C3, one falling edge → OUT_VALID 4 cycles later, OUT_DATA = A5C3, OUT_SEQ = 0.
- Edge select: CAPT_EDGE = 1, 10 CNVCLK periods → exactly 10 entries captured on rising edges, OUT_SEQ = 0..9.
- SR_OUT delay: SROUT_DELAY = 1, SR_OUT high on conversion 3 only → OUT_SROUT = 1 on the entry with OUT_SEQ = 4.
- Stuck: SR_OUT held high → SROUT_STUCK rises on conversion STUCK_LIMIT and later entries show OUT_SROUT = 0; CLR_STATUS clears the flag, and the next 200 conversions with SR_OUT high set it again.
- Overflow: OUT_READY = 0, 10 conversions, FIFO_DEPTH = 8 → OVERFLOW = 1; after draining, OUT_SEQ = 0..7, the next entry has OUT_SEQ = 10.
- Reset mid-stream: RST_N asserted with 3 entries queued → OUT_VALID = 0 immediately; after release, the next capture has OUT_SEQ = 0.
